// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch/PC stage: data width, fetch state encoding and the NOP word.
package fetch_pc_unit_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- what decode sees whenever no real instruction is present
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_range_chk.sv
// Legal-fetch window compare and redirect-target alignment handling.
// Behaviour of misaligned targets depends on FETCH_MISALIGN_TRAP_EN.
module fetch_range_chk
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned MEM_NBYTE = 4096
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] target_raw,
    output logic            legal,
    output logic            trap,
    output logic [XLEN-1:0] target
);

    logic [XLEN:0] last_byte;

    // One extra bit keeps a pc near 2^32 from wrapping back into the legal window
    assign last_byte = {1'b0, pc} + (XLEN+1)'(3);
    assign legal     = last_byte < (XLEN+1)'(MEM_NBYTE);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap   = |target_raw[1:0];
    assign target = target_raw;
`else
    assign trap   = 1'b0;
    assign target = target_raw & ~XLEN'(3);
`endif

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and fetch control in front of a combinational IMEM; sticky halt on bad fetches.
// Optional: FETCH_MISALIGN_TRAP_EN makes misaligned redirects halt instead of being truncated.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     MEM_NBYTE = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_inst,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc4,
    output logic [XLEN-1:0] if_inst,
    output logic            if_valid,
    output logic            halted,
    output logic            misalign,
    output logic [XLEN-1:0] fetch_cnt
);

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            legal;
    logic            trap;
    logic [XLEN-1:0] target;

    fetch_range_chk #(
        .MEM_NBYTE (MEM_NBYTE)
    ) u_range_chk (
        .pc         (pc),
        .target_raw (redirect_pc),
        .legal      (legal),
        .trap       (trap),
        .target     (target)
    );

    assign imem_addr = pc;
    assign if_pc     = pc;
    assign if_pc4    = pc + XLEN'(4);
    assign if_valid  = (state == RUN) && legal;
    assign if_inst   = if_valid ? imem_inst : NOP_INST;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    // A range fault beats both stall and redirect; a stall beats a redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            halted    <= 1'b0;
            fetch_cnt <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (legal && !stall && fetch_cnt != '1) begin
                        fetch_cnt <= fetch_cnt + XLEN'(1);
                    end
                    if (!legal) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (!stall && redirect_valid) begin
                        if (trap) begin
                            state  <= HALT;
                            halted <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                            misalign_q <= 1'b1;
`endif
                        end else begin
                            pc <= target;
                        end
                    end else if (!stall) begin
                        pc <= pc + XLEN'(4);
                    end
                end
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed vector table, hand sequences for the
// range-end halt and asynchronous reset, then randomized traffic against a reference model.
module tb_fetch_pc_unit;

    localparam int unsigned MEM_NBYTE = 4096;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [31:0] MEM_SALT  = 32'hC0DE_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        halted;
    logic        misalign;
    logic [31:0] fetch_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: architectural view only
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_halted;
    bit          m_mis;
    logic [31:0] m_cnt;

    fetch_pc_unit #(
        .RESET_PC  (32'h0000_0000),
        .MEM_NBYTE (MEM_NBYTE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .if_inst        (if_inst),
        .if_valid       (if_valid),
        .halted         (halted),
        .misalign       (misalign),
        .fetch_cnt      (fetch_cnt)
    );

    // Combinational IMEM whose contents are a recognisable function of the address
    assign imem_inst = MEM_SALT ^ imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          stall;
        bit          rv;
        logic [31:0] rpc;
        logic [31:0] e_pc;
        bit          e_valid;
        bit          e_halted;
        bit          e_mis;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[14];

    function automatic bit modelLegal(input logic [31:0] p);
        return (longint'(p) + 3) < longint'(MEM_NBYTE);
    endfunction

    function automatic bit modelValid();
        return !m_boot && !m_halted && modelLegal(m_pc);
    endfunction

    task automatic modelReset();
        m_pc     = 32'h0;
        m_boot   = 1'b1;
        m_halted = 1'b0;
        m_mis    = 1'b0;
        m_cnt    = 32'h0;
    endtask

    task automatic modelStep(input bit s, input bit rv, input logic [31:0] rpc);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_halted) begin
            if (modelLegal(m_pc) && !s && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (!modelLegal(m_pc)) begin
                m_halted = 1'b1;
            end else if (!s && rv) begin
                if (TRAP_EN && (rpc % 4) != 0) begin
                    m_halted = 1'b1;
                    m_mis    = 1'b1;
                end else begin
                    m_pc = rpc - (rpc % 4);
                end
            end else if (!s) begin
                m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] e_pc, input bit e_valid,
                               input bit e_halted, input bit e_mis, input logic [31:0] e_cnt);
        cmp({tag, ".if_pc"}, if_pc, e_pc);
        cmp({tag, ".imem_addr"}, imem_addr, e_pc);
        cmp({tag, ".if_pc4"}, if_pc4, e_pc + 32'd4);
        cmp({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, e_valid});
        cmp({tag, ".if_inst"}, if_inst, e_valid ? (MEM_SALT ^ e_pc) : NOP_WORD);
        cmp({tag, ".halted"}, {31'b0, halted}, {31'b0, e_halted});
        cmp({tag, ".misalign"}, {31'b0, misalign}, {31'b0, e_mis});
        cmp({tag, ".fetch_cnt"}, fetch_cnt, e_cnt);
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, m_pc, modelValid(), m_halted, m_mis, m_cnt);
    endtask

    // Called at a falling edge: drive inputs and let the combinational path settle
    task automatic applyStimulus(input bit s, input bit rv, input logic [31:0] rpc);
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        modelStep(stall, redirect_valid, redirect_pc);
        @(negedge clk);
    endtask

    task automatic cycle(input string tag, input bit s, input bit rv, input logic [31:0] rpc);
        applyStimulus(s, rv, rpc);
        checkModel(tag);
        advance();
    endtask

    task automatic doReset();
        rst = 1'b1;
        modelReset();
        applyStimulus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        doReset();

        // stall, rv, rpc, exp pc, valid, halted, misalign, fetch_cnt
        vecs[0]  = '{0, 0, 32'h00, 32'h00, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 32'h00, 32'h00, 1, 0, 0, 0};
        vecs[2]  = '{0, 0, 32'h00, 32'h04, 1, 0, 0, 1};
        vecs[3]  = '{1, 1, 32'h40, 32'h08, 1, 0, 0, 2};
        vecs[4]  = '{1, 1, 32'h40, 32'h08, 1, 0, 0, 2};
        vecs[5]  = '{1, 1, 32'h40, 32'h08, 1, 0, 0, 2};
        vecs[6]  = '{0, 1, 32'h40, 32'h08, 1, 0, 0, 2};
        vecs[7]  = '{0, 0, 32'h00, 32'h40, 1, 0, 0, 3};
        vecs[8]  = '{0, 1, 32'h0C, 32'h44, 1, 0, 0, 4};
        vecs[9]  = '{0, 1, 32'h10, 32'h0C, 1, 0, 0, 5};
        vecs[10] = '{0, 0, 32'h00, 32'h10, 1, 0, 0, 6};
        vecs[11] = '{0, 1, 32'h06, 32'h14, 1, 0, 0, 7};
`ifdef FETCH_MISALIGN_TRAP_EN
        vecs[12] = '{0, 0, 32'h00, 32'h14, 0, 1, 1, 8};
        vecs[13] = '{0, 1, 32'h20, 32'h14, 0, 1, 1, 8};
`else
        vecs[12] = '{0, 0, 32'h00, 32'h04, 1, 0, 0, 8};
        vecs[13] = '{0, 1, 32'h20, 32'h08, 1, 0, 0, 9};
`endif

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].rv, vecs[i].rpc);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid,
                        vecs[i].e_halted, vecs[i].e_mis, vecs[i].e_cnt);
            checkModel($sformatf("vec%0d.model", i));
            advance();
        end

        // Run off the end of IMEM; halt must beat a simultaneous redirect and stay frozen
        doReset();
        cycle("end.boot", 1'b0, 1'b0, 32'h0);
        cycle("end.jump", 1'b0, 1'b1, 32'h0000_0FF0);
        for (int i = 0; i < 3; i++) cycle($sformatf("end.seq%0d", i), 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("end.last", 32'h0000_0FFC, 1'b1, 1'b0, 1'b0, 32'd4);
        advance();
        applyStimulus(1'b0, 1'b1, 32'h0000_0020);
        checkOutput("end.oob", 32'h0000_1000, 1'b0, 1'b0, 1'b0, 32'd5);
        advance();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h0000_0020);
            checkOutput($sformatf("end.frozen%0d", i), 32'h0000_1000, 1'b0, 1'b1, 1'b0, 32'd5);
            advance();
        end

        // Asynchronous reset in the middle of a redirect at pc 0x40
        doReset();
        cycle("ar.boot", 1'b0, 1'b0, 32'h0);
        cycle("ar.jump", 1'b0, 1'b1, 32'h0000_0040);
        applyStimulus(1'b0, 1'b1, 32'h0000_0100);
        checkOutput("ar.pre", 32'h0000_0040, 1'b1, 1'b0, 1'b0, 32'd1);
        #1;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("ar.async", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cycle("ar.boot2", 1'b0, 1'b0, 32'h0);
        cycle("ar.run", 1'b0, 1'b0, 32'h0);

        // Randomized traffic, re-resetting sometimes after a halt
        for (int i = 0; i < 800; i++) begin
            logic [31:0] rpc;
            int          kind;
            kind = $urandom_range(0, 9);
            if (kind <= 6)      rpc = $urandom_range(0, 1023) * 4;
            else if (kind == 7) rpc = $urandom_range(0, 1023) * 4 + $urandom_range(1, 3);
            else if (kind == 8) rpc = 32'h0000_0FE0 + $urandom_range(0, 31);
            else                rpc = $urandom;
            if (m_halted && $urandom_range(0, 7) == 0) begin
                doReset();
            end else begin
                cycle($sformatf("rnd%0d", i), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 4) == 0, rpc);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and fetch-control stage sitting directly upstream of the combinational instruction memory of the single-cycle RISC-V core. Holds the architectural PC, drives the IMEM byte address, captures the returned 32-bit word, and presents instruction plus PC to decode with a valid flag. Handles sequential advance, branch/jump redirect, stall, and out-of-range/misaligned fetch detection with a sticky halt.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- MEM_NBYTE, 4096, IMEM size in bytes; legal fetch requires pc+3 < MEM_NBYTE
- NOP_INST, 32'h0000_0013, word presented on if_inst when if_valid=0 (addi x0,x0,0)

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold PC and outputs this cycle
- redirect_valid  in  1  load redirect_pc as next PC
- redirect_pc  in  32  branch/jump target
- imem_addr  out  32  byte address to IMEM; equals pc
- imem_inst  in  32  word returned by IMEM, same cycle
- if_pc  out  32  PC of if_inst
- if_pc4  out  32  if_pc + 4, mod 2^32
- if_inst  out  32  instruction to decode
- if_valid  out  1  if_inst is a real fetched instruction
- halted  out  1  sticky fetch fault
- misalign  out  1  sticky: halt caused by misaligned redirect
- fetch_cnt  out  32  retired-fetch counter, saturating

## Operation
- States: BOOT, RUN, HALT. Reset → BOOT.
- BOOT: one cycle, if_valid=0, pc=RESET_PC; next state RUN unconditionally (RESET_PC range not checked in BOOT).
- RUN: imem_addr=pc; if_inst=imem_inst, if_valid=1 when pc legal. Next PC at clock edge:
  - stall=1: pc held; redirect ignored (requester must hold redirect_valid until stall drops).
  - else redirect_valid=1: pc←redirect_pc (subject to Configuration).
  - else pc←pc+4.
- Range check (combinational, RUN): pc+3 ≥ MEM_NBYTE → if_valid=0, if_inst=NOP_INST, next state HALT, halted←1 at edge. Compare done in 33 bits so pc near 2^32 does not wrap into range.
- HALT: pc frozen, if_valid=0, if_inst=NOP_INST, halted=1; exit only via rst.
- fetch_cnt increments on each edge in RUN with if_valid=1 and stall=0; saturates at 32'hFFFF_FFFF.
- if_pc=pc, if_pc4=pc+4 in all states.

## Timing
- Reset values: pc=RESET_PC, state=BOOT, halted=0, misalign=0, fetch_cnt=0; imem_addr=RESET_PC, if_valid=0, if_inst=NOP_INST.
- Zero-latency fetch: imem_addr→imem_inst→if_inst combinational in one cycle; PC update on next rising edge.
- Redirect takes effect one edge after sampling; no delay slot, no squash needed.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronous), regardless of stall/redirect.
- Simultaneous stall+redirect: stall wins. Simultaneous redirect + out-of-range current pc: HALT wins.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0]≠0 (accepted, not stalled) → pc not updated, next state HALT, halted←1, misalign←1.
- Undefined: redirect_pc low two bits forced to 0 silently; misalign tied 0; halt only from range fault.

## Structure
- Shared package: state enum (BOOT/RUN/HALT), NOP_INST constant, XLEN=32.
- One sub-module natural: fetch_range_chk (combinational 33-bit legal-address compare against MEM_NBYTE, plus alignment check).
- PC register, state register, counter in top.

## Test plan
- Reset release, no stall/redirect, IMEM preloaded → BOOT cycle valid=0, then if_pc 0,4,8,… each cycle, fetch_cnt=N after N valid fetches.
- Redirect to 0x10 while pc=0x0C → next if_pc=0x10, no skipped or duplicated instruction.
- stall=1 for 3 cycles with redirect_valid=1, pc=0x08 → pc stays 0x08, fetch_cnt unchanged; on release next pc=redirect target.
- Sequential run to pc=MEM_NBYTE-4 then +4 (4096) → last valid at 0xFFC, then if_valid=0, halted=1, pc frozen until rst.
- Redirect to 0x0000_0006: with FETCH_MISALIGN_TRAP_EN → halted=1, misalign=1; without → next pc=0x04, continues.
- Assert rst asynchronously mid-redirect at pc=0x40 → outputs return to reset values before next clock edge.
